// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisor table, 16x oversample factor and frame lengths.
// Used by both the byte transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE     = 16;
  localparam int FRAME_BITS     = 10;
  localparam int FRAME_BITS_PAR = 11;
  localparam int PERIOD_W       = 14;
  localparam logic [2:0] BAUD_RST = 3'd1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } tx_state_e;

  // Divisor per baud index; bit period is OVERSAMPLE*(DR+1) clocks at 50 MHz.
  function automatic logic [9:0] baud_dr(input logic [2:0] idx);
    logic [9:0] dr;
    case (idx)
      3'd0:    dr = 10'd650;
      3'd1:    dr = 10'd324;
      3'd2:    dr = 10'd162;
      3'd3:    dr = 10'd80;
      3'd4:    dr = 10'd53;
      3'd5:    dr = 10'd41;
      3'd6:    dr = 10'd26;
      default: dr = 10'd13;
    endcase
    return dr;
  endfunction

  function automatic logic [PERIOD_W-1:0] bit_period(input logic [2:0] idx);
    return PERIOD_W'(OVERSAMPLE * (int'(baud_dr(idx)) + 1));
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..P-1 while enabled and pulses bit_end on the last count.
// Held at zero whenever disabled, so every frame starts with a full bit period.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] baud_idx,
  input  logic       en,
  output logic       bit_end
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W-1:0] last_cnt;

  always_comb begin
    last_cnt = bit_period(baud_idx) - PERIOD_W'(1);
    bit_end  = en && (cnt_q == last_cnt);
    cnt_d    = cnt_q + PERIOD_W'(1);
    if (!en || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx_multibaud.sv
// UART byte transmitter with eight selectable baud rates, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module uart_byte_tx_multibaud
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] baud_set,
  input  logic [7:0] data_byte,
  input  logic       Send_En,
  output logic       uart_tx,
  output logic       Tx_Done,
  output logic       uart_state
);

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = FRAME_BITS_PAR;
`else
  localparam int NBITS = FRAME_BITS;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);

  tx_state_e  state_q, state_d;
  logic       tx_q, tx_d;
  logic [3:0] bit_idx_q, bit_idx_d;
  logic [7:0] data_q, data_d;
  logic [2:0] baud_q, baud_d;
  logic       bit_end;
  logic       tx_done;

  // Line level for a given frame position: start, data LSB first, [parity], stop.
  function automatic logic line_bit(input logic [3:0] idx, input logic [7:0] data);
    logic b;
    if (idx == 4'd0) begin
      b = 1'b0;
    end else if (idx <= 4'd8) begin
      b = data[3'(idx - 4'd1)];
`ifdef UART_TX_PARITY_EN
    end else if (idx == 4'd9) begin
      b = ^data;
`endif
    end else begin
      b = 1'b1;
    end
    return b;
  endfunction

  uart_tx_bit_timer u_bit_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .baud_idx (baud_q),
    .en       (state_q == ST_BUSY),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    baud_d    = baud_q;
    tx_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        bit_idx_d = 4'd0;
        if (Send_En) begin
          state_d = ST_BUSY;
          data_d  = data_byte;
          baud_d  = baud_set;
          tx_d    = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            // Done coincides with the final stop-bit cycle; idle follows next cycle.
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
            bit_idx_d = 4'd0;
            tx_done   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = line_bit(bit_idx_q + 4'd1, data_q);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      bit_idx_q <= 4'd0;
      data_q    <= 8'd0;
      baud_q    <= BAUD_RST;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      baud_q    <= baud_d;
    end
  end

  assign uart_tx    = tx_q;
  assign uart_state = (state_q == ST_BUSY);
  assign Tx_Done    = tx_done;

endmodule

// File: tb/tb_uart_byte_tx_multibaud.sv
// Directed bench for uart_byte_tx_multibaud: frame timing, mid-frame input changes,
// back-to-back frames and mid-frame reset. Honours UART_TX_PARITY_EN.
module tb_uart_byte_tx_multibaud;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       Send_En;
  logic       uart_tx;
  logic       Tx_Done;
  logic       uart_state;

  int errors = 0;
  int checks = 0;

  always #10 Clk = ~Clk;

  uart_byte_tx_multibaud dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .Send_En    (Send_En),
    .uart_tx    (uart_tx),
    .Tx_Done    (Tx_Done),
    .uart_state (uart_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Follows a frame cycle by cycle from the first cycle after acceptance.
  // inj_kind 1: pulse Send_En with 0xA3 mid bit inj_bit; 2: switch baud_set to 7 and data.
  // stop_c > 0 returns early after that many cycles (used before a reset).
  task automatic check_frame(input logic [7:0] b, input int p, input string tag,
                             input int inj_bit, input int inj_kind, input int stop_c);
    int   last_c;
    int   bi;
    int   pos;
    int   glitch;
    int   dones;
    logic eb;
    last_c = (stop_c > 0) ? stop_c : NB * p;
    glitch = 0;
    dones  = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge Clk);
      bi  = (c - 1) / p;
      pos = (c - 1) % p;
      Send_En = 1'b0;
      if (inj_kind != 0 && bi == inj_bit && pos == p / 2) begin
        if (inj_kind == 1) begin
          Send_En   = 1'b1;
          data_byte = 8'hA3;
        end else begin
          baud_set  = 3'd7;
          data_byte = 8'hAA;
        end
      end
      eb = exp_bit(b, bi);
      if (Tx_Done === 1'b1) dones++;
      if (pos == 0 || pos == p - 1) begin
        chk($sformatf("%s_tx_b%0d_p%0d", tag, bi, pos), uart_tx, eb);
        chk($sformatf("%s_busy_b%0d_p%0d", tag, bi, pos), uart_state, 1'b1);
      end else if (uart_tx !== eb || uart_state !== 1'b1) begin
        glitch++;
      end
      if (pos == p - 1) chk($sformatf("%s_done_b%0d", tag, bi), Tx_Done, (bi == NB - 1));
    end
    chk({tag, "_midbit_changes"}, glitch, 0);
    chk({tag, "_done_count"}, dones, (stop_c > 0) ? 0 : 1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge Clk);
    Send_En = 1'b0;
    chk({tag, "_state"}, uart_state, 1'b0);
    chk({tag, "_tx"}, uart_tx, 1'b1);
    chk({tag, "_done"}, Tx_Done, 1'b0);
  endtask

  initial begin
    int busy_seen;
    Rst       = 1'b1;
    Send_En   = 1'b0;
    data_byte = 8'h00;
    baud_set  = 3'd0;
    repeat (3) @(negedge Clk);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_state", uart_state, 1'b0);
    chk("rst_done", Tx_Done, 1'b0);

    // First edge after reset release accepts; baud switched to 7 during data bit 3.
    Rst       = 1'b0;
    Send_En   = 1'b1;
    data_byte = 8'h55;
    baud_set  = 3'd1;
    check_frame(8'h55, 5200, "f55", 4, 2, 0);
    idle_check("f55_end");

    // New frame at the index latched mid previous frame; Send_En mid-frame ignored.
    Send_En   = 1'b1;
    data_byte = 8'h0F;
    check_frame(8'h0F, 224, "f0f", 3, 1, 0);
    idle_check("f0f_end");
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (uart_state !== 1'b0 || Tx_Done !== 1'b0) busy_seen++;
    end
    chk("f0f_no_queued_frame", busy_seen, 0);

    // Back-to-back at baud 3: stop bit stretched to P+1.
    Send_En   = 1'b1;
    data_byte = 8'hFF;
    baud_set  = 3'd3;
    check_frame(8'hFF, 1296, "fff", 0, 0, 0);
    idle_check("fff_stop_extra");
    Send_En   = 1'b1;
    data_byte = 8'h00;
    check_frame(8'h00, 1296, "f00", 0, 0, 0);
    idle_check("f00_end");

    // Reset in the middle of data bit 5 (a zero bit for 0x1C).
    Send_En   = 1'b1;
    data_byte = 8'h1C;
    baud_set  = 3'd7;
    check_frame(8'h1C, 224, "frst", 0, 0, 6 * 224 + 112);
    chk("frst_before_tx", uart_tx, 1'b0);
    #3 Rst = 1'b1;
    #1;
    chk("frst_async_tx", uart_tx, 1'b1);
    chk("frst_async_state", uart_state, 1'b0);
    chk("frst_async_done", Tx_Done, 1'b0);
    repeat (3) begin
      @(negedge Clk);
      chk("frst_hold_done", Tx_Done, 1'b0);
      chk("frst_hold_tx", uart_tx, 1'b1);
    end
    Rst       = 1'b0;
    Send_En   = 1'b1;
    data_byte = 8'h07;
    baud_set  = 3'd7;
    check_frame(8'h07, 224, "f07", 0, 0, 0);
    idle_check("f07_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx_multibaud.md
UART_BYTE_TX_MULTIBAUD -- requirements
Module: uart_byte_tx_multibaud

Interface
REQ-001 SHALL have port Clk, input, 1, single system clock (50 MHz); all logic on its rising edge.
REQ-002 SHALL have port Rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port baud_set, input, 3, baud selection index 0..7.
REQ-004 SHALL have port data_byte, input, 8, byte to transmit.
REQ-005 SHALL have port Send_En, input, 1, one-cycle send request.
REQ-006 SHALL have port uart_tx, output, 1, registered serial line; idle high.
REQ-007 SHALL have port Tx_Done, output, 1, one-cycle frame-complete pulse.
REQ-008 SHALL have port uart_state, output, 1, busy flag, high while a frame is in progress.

Function
REQ-009 SHALL use bit period P = 16*(DR+1) clocks, with DR per baud_set 0..7 = 650,324,162,80,53,41,26,13, giving P = 10416,5200,2608,1296,864,672,432,224.
REQ-010 SHALL accept Send_En only when uart_state=0, latching data_byte and baud_set on that edge; Send_En while busy SHALL be ignored with no queuing.
REQ-011 SHALL go busy one cycle after acceptance: uart_state=1 and uart_tx=0 (start bit) in the same cycle.
REQ-012 SHALL send the frame as start(0), data[0]..data[7] LSB first, then stop(1); each bit SHALL last exactly P cycles, for a 10*P frame.
REQ-013 SHALL use a bit-period counter 0..P-1 and a bit index 0..9 (0..10 with parity); both clear on idle and on acceptance.
REQ-014 SHALL assert Tx_Done for exactly one cycle, coincident with the last cycle of the stop bit.
REQ-015 SHALL deassert uart_state the cycle after Tx_Done, with uart_tx held at 1.
REQ-016 SHALL accept a Send_En in the first idle cycle; back-to-back frames SHALL therefore have a stop bit of P+1 cycles minimum.
REQ-017 SHALL ignore baud_set and data_byte changes mid-frame, using the latched copies.
REQ-018 SHALL never emit a glitch on uart_tx; it SHALL change only at bit boundaries.

Reset
REQ-019 SHALL, on Rst assertion (including mid-frame), immediately force uart_tx=1, Tx_Done=0, uart_state=0, all counters=0 and latched data=0, with no Tx_Done for the aborted frame.
REQ-020 SHALL reset the latched baud index to 1 (P=5200).
REQ-021 SHALL accept Send_En on the first edge after Rst deasserts.

Configuration
REQ-022 SHALL, when macro UART_TX_PARITY_EN is defined, insert an even-parity bit (XOR of the 8 data bits) between data[7] and stop; the frame SHALL be 11*P and the bit index 0..10.
REQ-023 SHALL, when UART_TX_PARITY_EN is undefined, contain no parity logic and produce a 10*P frame.

Structure
REQ-024 SHALL place the DR table, the frame-length constants (10/11 bits) and the 16x oversample factor in shared package uart_pkg, also used by the receiver.
REQ-025 SHALL instantiate sub-module uart_tx_bit_timer, which takes the latched baud index and an enable and produces a one-cycle bit_end tick every P cycles; the top level holds the shift/bit FSM.

Verification
REQ-026 SHALL verify: baud_set=1, data_byte=0x55, Send_En pulse at edge T -> uart_tx low at T+1 for 5200 cycles, then bits 1,0,1,0,1,0,1,0 of 5200 cycles each, stop high, Tx_Done at T+52000, uart_state low at T+52001.
REQ-027 SHALL verify: Send_En with 0xA3 pulsed mid-frame while sending 0x0F at baud_set=7 -> only 0x0F is transmitted (224-cycle bits) and exactly one Tx_Done occurs.
REQ-028 SHALL verify: baud_set changed 1->7 during data bit 3 -> all bits of the frame remain 5200 cycles; the next frame uses 224.
REQ-029 SHALL verify: Rst pulsed during data bit 5 -> uart_tx=1 asynchronously, uart_state=0, no Tx_Done; a new Send_En after release produces a complete frame.
REQ-030 SHALL verify: Send_En in the cycle after Tx_Done with 0xFF then 0x00 at baud_set=3 -> stop bit lasts 1297 cycles and the second start bit follows immediately.
REQ-031 SHALL verify, with UART_TX_PARITY_EN defined: data 0x07 -> parity bit=1, frame 11*P, Tx_Done at T+11*P.
